// File: rtl/mux_arb_i8_pkg.sv
// Shared encodings for the two-source arbitrated mux: output slot state,
// source identifiers and the per-source beat counter width.
package mux_arb_i8_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Source encoding doubles as the mux cond polarity: 1 selects A.
  typedef enum logic {
    SRC_B = 1'b0,
    SRC_A = 1'b1
  } src_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mux_arb_i8_rr_arb2.sv
// Two-requester grant logic: fixed priority to A or round-robin against the
// previously granted source; nothing is granted unless en is high.
module rr_arb2
  import mux_arb_i8_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic prio,
  input  logic last_grant,
  input  logic en,
  output logic grant_a,
  output logic grant_b
);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        // On a tie A wins under fixed priority or when B was served last.
        if (prio || (last_grant == SRC_B)) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

endmodule

// File: rtl/mux_i8_b_i8_i8.sv
// Existing two-input data select cell: y = cond ? a : b.
module mux_i8_b_i8_i8 #(
  parameter int WIDTH = 8
) (
  input  logic             cond,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = cond ? a : b;

endmodule

// File: rtl/mux_arb_i8.sv
// Two-source valid/ready arbiter feeding a single-entry output register,
// with per-source wrapping beat counters.
module mux_arb_i8
  import mux_arb_i8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             prio,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_sel,
  input  logic             y_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  state_t           state;
  state_t           state_next;
  src_t             last_grant;
  logic             slot_free;
  logic             arb_en;
  logic             grant_a;
  logic             grant_b;
  logic             grant;
  logic [WIDTH-1:0] mux_y;

  // The slot may be refilled in the same cycle it drains; reset blocks grants.
  assign slot_free = (state == EMPTY) || y_ready;
  assign arb_en    = slot_free && !reset;
  assign grant     = grant_a || grant_b;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign y_valid   = (state == FULL);

  rr_arb2 u_arb (
    .req_a      (a_valid),
    .req_b      (b_valid),
    .prio       (prio),
    .last_grant (last_grant),
    .en         (arb_en),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  mux_i8_b_i8_i8 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .cond (grant_a),
    .a    (a_data),
    .b    (b_data),
    .y    (mux_y)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (grant) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (y_ready && !grant) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Beat register, round-robin history and counters only move on a transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_data     <= '0;
      y_sel      <= 1'b0;
      last_grant <= SRC_B;
      cnt_a      <= '0;
      cnt_b      <= '0;
    end else if (grant) begin
      y_data     <= mux_y;
      y_sel      <= grant_a;
      last_grant <= grant_a ? SRC_A : SRC_B;
      if (grant_a) begin
        cnt_a <= cnt_a + 1'b1;
      end
      if (grant_b) begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_i8.sv
// Directed self-checking bench for mux_arb_i8 with hand-computed expectations.
module tb_mux_arb_i8;

  logic       clock;
  logic       reset;
  logic       prio;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       y_valid;
  logic [7:0] y_data;
  logic       y_sel;
  logic       y_ready;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int assertCount = 0;
  int failCount   = 0;

  mux_arb_i8 #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .prio    (prio),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_sel   (y_sel),
    .y_ready (y_ready),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [7:0] ad,
                               input logic bv, input logic [7:0] bd,
                               input logic yr, input logic pr);
    a_valid = av;
    a_data  = ad;
    b_valid = bv;
    b_data  = bd;
    y_ready = yr;
    prio    = pr;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
    #1;
  endtask

  logic [7:0] rrExp [4];

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Long reset with valids offered: readys must stay low throughout.
    for (int i = 0; i < 16; i++) step();
    applyStimulus(1'b1, 8'd9, 1'b1, 8'd7, 1'b1, 1'b0);
    checkOutput("reset_a_ready", a_ready, 0);
    checkOutput("reset_b_ready", b_ready, 0);
    step();
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("rst_y_valid", y_valid, 0);
    checkOutput("rst_y_data", y_data, 0);
    checkOutput("rst_y_sel", y_sel, 0);
    checkOutput("rst_cnt_a", cnt_a, 0);
    checkOutput("rst_cnt_b", cnt_b, 0);
    step();
    checkOutput("idle_a_ready", a_ready, 0);
    checkOutput("idle_b_ready", b_ready, 0);
    checkOutput("idle_y_valid", y_valid, 0);

    // Single A beat.
    applyStimulus(1'b1, 8'd2, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("single_a_ready", a_ready, 1);
    checkOutput("single_b_ready", b_ready, 0);
    step();
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("single_y_valid", y_valid, 1);
    checkOutput("single_y_data", y_data, 2);
    checkOutput("single_y_sel", y_sel, 1);
    checkOutput("single_cnt_a", cnt_a, 1);
    step();
    checkOutput("drain_y_valid", y_valid, 0);
    checkOutput("drain_y_data_kept", y_data, 2);

    // Round-robin from reset: A wins the first tie then alternates.
    doReset(2);
    rrExp[0] = 8'd2; rrExp[1] = 8'd6; rrExp[2] = 8'd2; rrExp[3] = 8'd6;
    applyStimulus(1'b1, 8'd2, 1'b1, 8'd6, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_a_ready_%0d", i), a_ready, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr_b_ready_%0d", i), b_ready, (i % 2 == 0) ? 0 : 1);
      step();
      checkOutput($sformatf("rr_y_data_%0d", i), y_data, rrExp[i]);
      checkOutput($sformatf("rr_y_sel_%0d", i), y_sel, (i % 2 == 0) ? 1 : 0);
    end
    checkOutput("rr_cnt_a", cnt_a, 2);
    checkOutput("rr_cnt_b", cnt_b, 2);

    // Fixed priority: B is never served while A is valid.
    doReset(2);
    applyStimulus(1'b1, 8'd2, 1'b1, 8'd6, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("prio_b_ready_%0d", i), b_ready, 0);
      step();
      checkOutput($sformatf("prio_y_data_%0d", i), y_data, 2);
    end
    checkOutput("prio_cnt_a", cnt_a, 3);
    checkOutput("prio_cnt_b", cnt_b, 0);

    // Backpressure hold with both sources still offering.
    doReset(2);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd6, 1'b1, 1'b0);
    step();
    checkOutput("hold_load_y_data", y_data, 6);
    applyStimulus(1'b1, 8'd2, 1'b1, 8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_a_ready_%0d", i), a_ready, 0);
      checkOutput($sformatf("hold_b_ready_%0d", i), b_ready, 0);
      step();
      checkOutput($sformatf("hold_y_data_%0d", i), y_data, 6);
      checkOutput($sformatf("hold_y_valid_%0d", i), y_valid, 1);
      checkOutput($sformatf("hold_y_sel_%0d", i), y_sel, 0);
    end
    applyStimulus(1'b1, 8'd2, 1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("refill_a_ready", a_ready, 1);
    step();
    checkOutput("refill_y_data", y_data, 2);
    checkOutput("refill_y_sel", y_sel, 1);
    checkOutput("refill_y_valid", y_valid, 1);
    checkOutput("refill_cnt_a", cnt_a, 1);
    checkOutput("refill_cnt_b", cnt_b, 1);

    // Counter wrap, then reset discards a held beat.
    doReset(2);
    applyStimulus(1'b1, 8'd3, 1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 255; i++) step();
    checkOutput("wrap_cnt_a_255", cnt_a, 255);
    step();
    checkOutput("wrap_cnt_a_0", cnt_a, 0);
    checkOutput("wrap_cnt_b", cnt_b, 0);
    applyStimulus(1'b1, 8'd4, 1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("pre_rst_y_valid", y_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_a_ready", a_ready, 0);
    step();
    checkOutput("mid_rst_y_valid", y_valid, 0);
    checkOutput("mid_rst_y_data", y_data, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step();
    checkOutput("post_rst_y_valid", y_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
